// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Write handshake and serial status bundle for uart_tx_fifo.
// Revision : 1.0
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH_LOG2 = 3
);
    logic                     i_wr_valid;
    logic [7:0]               i_wr_byte;
    logic                     o_wr_ready;
    logic                     o_tx_line;
    logic                     o_tx_busy;
    logic                     o_byte_done;
    logic [FIFO_DEPTH_LOG2:0] o_fifo_count;

    modport master (
        output i_wr_valid,
        output i_wr_byte,
        input  o_wr_ready,
        input  o_tx_line,
        input  o_tx_busy,
        input  o_byte_done,
        input  o_fifo_count
    );

    modport slave (
        input  i_wr_valid,
        input  i_wr_byte,
        output o_wr_ready,
        output o_tx_line,
        output o_tx_busy,
        output o_byte_done,
        output o_fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : FIFO-buffered 8N1 UART transmitter, LSB first. Defining
//            UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BAUD_PERIOD = 434,
    parameter int FIFO_DEPTH_LOG2      = 3
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    uart_tx_fifo_if.slave   bus
);

    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int BAUD_W = (CLKS_PER_BAUD_PERIOD > 1) ? $clog2(CLKS_PER_BAUD_PERIOD) : 1;
    localparam logic [BAUD_W-1:0]        BAUD_LAST  = BAUD_W'(CLKS_PER_BAUD_PERIOD - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [2:0]                 bit_idx_q, bit_idx_d;
    logic [7:0]                 shift_q, shift_d;
    logic                       line_q, line_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
    logic                       parity_q, parity_d;
`endif

    logic w_push;
    logic w_pop;
    logic w_bit_end;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        line_d    = line_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        w_push    = bus.i_wr_valid && ready_q;
        w_pop     = 1'b0;
        w_bit_end = (baud_q == BAUD_LAST);

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    w_pop   = 1'b1;
                    state_d = ST_START;
                    line_d  = 1'b0;
                    baud_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    state_d = ST_DATA;
                    line_d  = shift_q[0];
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        line_d  = parity_q;
`else
                        state_d = ST_STOP;
                        line_d  = 1'b1;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        line_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    state_d = ST_STOP;
                    line_d  = 1'b1;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    done_d = 1'b1;
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (count_q != '0) begin
                        w_pop   = 1'b1;
                        state_d = ST_START;
                        line_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (w_pop) begin
            shift_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_COUNT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            line_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.i_wr_byte;
        end
    end

    assign bus.o_wr_ready   = ready_q;
    assign bus.o_tx_line    = line_q;
    assign bus.o_tx_busy    = busy_q;
    assign bus.o_byte_done  = done_q;
    assign bus.o_fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Self-checking bench for uart_tx_fifo against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;

    localparam int N     = 4;
    localparam int L     = 3;
    localparam int DEPTH = 1 << L;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * N;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    uart_tx_fifo_if #(.FIFO_DEPTH_LOG2(L)) bus ();

    uart_tx_fifo #(
        .CLKS_PER_BAUD_PERIOD(N),
        .FIFO_DEPTH_LOG2     (L)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame model: bit j of a frame is start, data LSB first, optional parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (NBITS == 11 && j == 9) return ^b;
        return 1'b1;
    endfunction

    logic [7:0] mq[$];
    logic [7:0] m_byte = 8'h00;
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    int         m_pos  = 0;

    initial forever begin
        int  pre;
        bit  push;
        bit  pop;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_pos  = 0;
        end else begin
            pre    = mq.size();
            push   = bus.i_wr_valid && (pre != DEPTH);
            pop    = 1'b0;
            m_done = 1'b0;
            if (!m_busy) begin
                if (pre > 0) begin
                    pop    = 1'b1;
                    m_busy = 1'b1;
                    m_pos  = 0;
                end
            end else if (m_pos == FL - 1) begin
                m_done = 1'b1;
                if (pre > 0) begin
                    pop   = 1'b1;
                    m_pos = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_pos++;
            end
            if (pop)  m_byte = mq.pop_front();
            if (push) mq.push_back(bus.i_wr_byte);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        check("tx_line",    bus.o_tx_line,    m_busy ? frame_bit(m_byte, m_pos / N) : 1'b1);
        check("tx_busy",    bus.o_tx_busy,    m_busy);
        check("byte_done",  bus.o_byte_done,  m_done);
        check("fifo_count", bus.o_fifo_count, mq.size());
        check("wr_ready",   bus.o_wr_ready,   mq.size() != DEPTH);
    end

    // Serial receiver: samples each bit mid-period, records byte and start cycle.
    logic [7:0]  rx_q[$];
    int          rx_t[$];
    int          mon_cnt = -1;
    int          mon_start = 0;
    logic [10:0] mon_bits = '0;

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mon_cnt = -1;
        end else begin
            if (mon_cnt < 0) begin
                if (bus.o_tx_line == 1'b0) begin
                    mon_cnt   = 0;
                    mon_start = cyc;
                end
            end else begin
                mon_cnt++;
            end
            if (mon_cnt >= 0) begin
                if (mon_cnt % N == N / 2) mon_bits[mon_cnt / N] = bus.o_tx_line;
                if (mon_cnt == FL - 1) begin
                    rx_q.push_back(mon_bits[8:1]);
                    rx_t.push_back(mon_start);
                    mon_cnt = -1;
                end
            end
        end
    end

    task automatic write1(input logic [7:0] b);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_byte  = b;
        @(negedge clk);
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while ((bus.o_tx_busy || bus.o_fifo_count != 0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (k >= limit) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles", limit);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send_and_check(input logic [7:0] b, input logic [10:0] exp_bits);
        wait_idle(20 * FL);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_byte  = b;
        @(posedge clk);
        #1;
        check("lat_line_at_accept", bus.o_tx_line, 1'b1);
        check("lat_count_at_accept", bus.o_fifo_count, 1);
        @(negedge clk);
        bus.i_wr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("lat_line_after_1", bus.o_tx_line, 1'b0);
        check("busy_rises", bus.o_tx_busy, 1'b1);
        for (int c = 1; c <= FL; c++) begin
            @(posedge clk);
            #1;
            if (c < FL && c % N == N / 2) check("mid_bit", bus.o_tx_line, exp_bits[c / N]);
            if (c == FL - 1) check("done_before_end", bus.o_byte_done, 1'b0);
            if (c == FL) begin
                check("done_at_frame_end", bus.o_byte_done, 1'b1);
                check("busy_falls", bus.o_tx_busy, 1'b0);
            end
        end
    endtask

    initial begin
        int bad;
        int p;
        logic [10:0] e55;
        logic [10:0] e07;
        rst_n          = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_byte  = 8'h00;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_line",  bus.o_tx_line, 1'b1);
        check("rst_busy",  bus.o_tx_busy, 1'b0);
        check("rst_done",  bus.o_byte_done, 1'b0);
        check("rst_ready", bus.o_wr_ready, 1'b1);
        check("rst_count", bus.o_fifo_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_ready", bus.o_wr_ready, 1'b1);
        check("post_rst_line",  bus.o_tx_line, 1'b1);
        @(negedge clk);

        // Single frames with literal bit patterns
`ifdef UART_TX_PARITY_EN
        e55 = 11'b10010101010;
        e07 = 11'b11000001110;
`else
        e55 = 11'b01010101010;
        e07 = 11'b01000001110;
`endif
        send_and_check(8'h55, e55);
        send_and_check(8'h07, e07);

        // Fill: nine consecutive writes, then one dropped while full
        wait_idle(20 * FL);
        rx_q.delete();
        rx_t.delete();
        bus.i_wr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.i_wr_byte = 8'(i);
            @(negedge clk);
        end
        check("fill_count", bus.o_fifo_count, 8);
        check("fill_ready", bus.o_wr_ready, 1'b0);
        bus.i_wr_byte = 8'h99;
        @(negedge clk);
        bus.i_wr_valid = 1'b0;
        check("full_drop_count", bus.o_fifo_count, 8);
        wait_idle(20 * FL);
        check("fill_frames", rx_q.size(), 9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            check("fill_byte", rx_q[i], 8'(i));
            if (i > 0) check("fill_gap", rx_t[i] - rx_t[i-1], FL);
        end

        // Push on the exact edge where STOP ends with one byte queued
        rx_q.delete();
        rx_t.delete();
        write1(8'h3C);
        write1(8'hA5);
        repeat (FL - 1) @(negedge clk);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_byte  = 8'h5A;
        @(posedge clk);
        #1;
        check("pp_count", bus.o_fifo_count, 1);
        check("pp_line_no_gap", bus.o_tx_line, 1'b0);
        check("pp_done", bus.o_byte_done, 1'b1);
        @(negedge clk);
        bus.i_wr_valid = 1'b0;
        wait_idle(20 * FL);
        check("pp_frames", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("pp_byte0", rx_q[0], 8'h3C);
            check("pp_byte1", rx_q[1], 8'hA5);
            check("pp_byte2", rx_q[2], 8'h5A);
            check("pp_gap",   rx_t[2] - rx_t[1], FL);
        end

        // Reset during data bit 3 with two bytes queued
        rx_q.delete();
        write1(8'hF0);
        write1(8'h11);
        write1(8'h22);
        repeat (4 * N) @(negedge clk);
        check("mid_busy", bus.o_tx_busy, 1'b1);
        check("mid_count", bus.o_fifo_count, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_line",  bus.o_tx_line, 1'b1);
        check("mid_rst_count", bus.o_fifo_count, 0);
        check("mid_rst_busy",  bus.o_tx_busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3 * FL; i++) begin
            @(negedge clk);
            if (bus.o_tx_line == 1'b0 || bus.o_byte_done || bus.o_tx_busy) bad++;
        end
        check("no_activity_after_rst", bad, 0);
        check("no_frames_after_rst", rx_q.size(), 0);

        // Randomized traffic at several write densities
        foreach (e55[k]) begin
            if (k < 4) begin
                p = (k == 0) ? 2 : (k == 1) ? 10 : (k == 2) ? 40 : 150;
                for (int i = 0; i < 700; i++) begin
                    bus.i_wr_valid = ($urandom_range(0, p - 1) == 0);
                    bus.i_wr_byte  = 8'($urandom);
                    @(negedge clk);
                end
                bus.i_wr_valid = 1'b0;
            end
        end
        wait_idle(20 * FL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
